// File: rtl/lagarto0_pkg.sv
// Shared sizes, constants and the line-entry type for the instruction queue.
package lagarto0_pkg;

  localparam int ICACHE_LINE_SIZE = 128;
  localparam int ISA_SIZE         = 32;
  localparam int ADDR_SIZE        = 32;
  localparam int IQ_DEPTH         = 4;
  localparam int IQ_WORDS         = ICACHE_LINE_SIZE / ISA_SIZE;

  localparam logic [ISA_SIZE-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [ICACHE_LINE_SIZE-1:0] line;
    logic [ADDR_SIZE-1:0]        pc;
    logic [$clog2(IQ_WORDS)-1:0] idx;
  } iq_entry_t;

endpackage

// File: rtl/iq_word_sel.sv
// Picks the current instruction word out of one buffered line and forms its PC.
module iq_word_sel #(
  parameter int LINE_W = lagarto0_pkg::ICACHE_LINE_SIZE,
  parameter int INST_W = lagarto0_pkg::ISA_SIZE,
  parameter int AW     = lagarto0_pkg::ADDR_SIZE,
  parameter int IW     = $clog2(LINE_W / INST_W)
) (
  input  logic [LINE_W-1:0] line_i,
  input  logic [AW-1:0]     pc_i,
  input  logic [IW-1:0]     idx_i,
  input  logic              valid_i,
  output logic [INST_W-1:0] inst_o,
  output logic [AW-1:0]     inst_pc_o
);
  import lagarto0_pkg::*;

  logic [INST_W-1:0] w_word;
  logic [AW-1:0]     w_byte_off;

  assign w_word     = line_i[INST_W*idx_i +: INST_W];
  assign w_byte_off = AW'(idx_i) * AW'(INST_W / 8);

  // Empty queue presents a NOP at PC 0 so decode never sees stale data.
  assign inst_o    = valid_i ? w_word : INST_W'(NOP_INST);
  assign inst_pc_o = valid_i ? (pc_i + w_byte_off) : '0;

endmodule

// File: rtl/inst_queue.sv
// Line-granular instruction buffer: whole icache lines in, one word per cycle out to decode.
module inst_queue #(
  parameter int IQ_DEPTH = lagarto0_pkg::IQ_DEPTH,
  parameter int LINE_W   = lagarto0_pkg::ICACHE_LINE_SIZE,
  parameter int INST_W   = lagarto0_pkg::ISA_SIZE,
  parameter int AW       = lagarto0_pkg::ADDR_SIZE
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                wr_i,
  input  logic [LINE_W-1:0]                   line_i,
  input  logic [AW-1:0]                       line_pc_i,
  input  logic [$clog2(LINE_W/INST_W)-1:0]    wr_off_i,
  output logic                                full_o,
  output logic                                empty_o,
  output logic                                inst_valid_o,
  input  logic                                inst_ready_i,
  output logic [INST_W-1:0]                   inst_o,
  output logic [AW-1:0]                       inst_pc_o
);
  import lagarto0_pkg::*;

  localparam int WORDS = LINE_W / INST_W;
  localparam int IW    = $clog2(WORDS);
  localparam int PW    = $clog2(IQ_DEPTH);
  localparam int CW    = $clog2(IQ_DEPTH + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(IQ_DEPTH);

  logic [LINE_W-1:0] r_line [IQ_DEPTH];
  logic [AW-1:0]     r_pc   [IQ_DEPTH];
  logic [IW-1:0]     r_idx  [IQ_DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_pop;
  logic w_release;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Fullness is judged on the pre-edge count, so a release never lets a write through.
  assign w_wr      = wr_i && !w_full && !flush_i;
  assign w_pop     = !w_empty && inst_ready_i && !flush_i;
  assign w_release = w_pop && (r_idx[r_head] == LAST_IDX);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)      r_tail <= r_tail + 1'b1;
      if (w_release) r_head <= r_head + 1'b1;
      unique case ({w_wr, w_release})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is never reset; the control pointers alone decide what is live.
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_line[r_tail] <= line_i;
      r_pc[r_tail]   <= line_pc_i;
      r_idx[r_tail]  <= wr_off_i;
    end
    if (w_pop && !w_release) begin
      r_idx[r_head] <= r_idx[r_head] + 1'b1;
    end
  end

  assign full_o       = w_full;
  assign empty_o      = w_empty;
  assign inst_valid_o = !w_empty;

  iq_word_sel #(
    .LINE_W (LINE_W),
    .INST_W (INST_W),
    .AW     (AW),
    .IW     (IW)
  ) u_word_sel (
    .line_i    (r_line[r_head]),
    .pc_i      (r_pc[r_head]),
    .idx_i     (r_idx[r_head]),
    .valid_i   (!w_empty),
    .inst_o    (inst_o),
    .inst_pc_o (inst_pc_o)
  );

endmodule
